// File: rtl/banked_wram.sv
// banked_wram -- banked work RAM with a fixed window, a switchable window and
// a bank-select register.
//
// Optional feature (compile-time macro BANKED_WRAM_ECHO_EN): also decode
// BASE_ADDR+16'h2000..16'hfdff as an echo of the two windows, using the same
// offset mapping.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   rst   - asynchronous active-low reset
//   ena   - block enable; low means no access and no drive
//   rd    - bus read strobe
//   wr    - bus write strobe (wins over rd when both are high)
//   a     - 16-bit bus address
//   din   - write data
//   dout  - read data, valid for one cycle after a read, otherwise 8'hzz
//   bank  - currently selected switchable bank (never 0)
//   hit   - combinational: ena high and a decodes to this block
module banked_wram #(
    parameter logic [15:0] BASE_ADDR     = 16'hc000,
    parameter int          BANK_AW       = 12,
    parameter int          NUM_BANKS     = 8,
    parameter logic [15:0] BANK_REG_ADDR = 16'hff70,
    localparam int         BW            = $clog2(NUM_BANKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          rd,
    input  logic          wr,
    input  logic [15:0]   a,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [BW-1:0] bank,
    output logic          hit
);

    localparam int          MEM_AW    = BW + BANK_AW;
    localparam int          DEPTH     = NUM_BANKS << BANK_AW;
    localparam logic [16:0] SPAN      = 17'(2 << BANK_AW);
    localparam logic [16:0] MAIN_BASE = {1'b0, BASE_ADDR};
    localparam logic [16:0] ECHO_BASE = {1'b0, BASE_ADDR} + 17'h02000;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        ram_q_reg;
    logic [BW-1:0]     bank_reg;
    logic [BW-1:0]     bank_next;
    logic              valid_reg;
    logic              reg_sel_reg;
    logic [7:0]        reg_byte_reg;
    logic [7:0]        reg_rd_value;

    logic [16:0]       off_main;
    logic [16:0]       off_echo;
    logic [16:0]       off_sel;
    logic              in_main;
    logic              in_echo;
    logic              is_reg;
    logic              in_mem;
    logic              rd_go;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_index;
    logic [BW-1:0]     bank_sel;

    // ---------------- address decode ----------------
    assign off_main = {1'b0, a} - MAIN_BASE;
    assign off_echo = {1'b0, a} - ECHO_BASE;
    assign in_main  = ({1'b0, a} >= MAIN_BASE) && (off_main < SPAN);
`ifdef BANKED_WRAM_ECHO_EN
    assign in_echo  = ({1'b0, a} >= ECHO_BASE) && (a <= 16'hfdff);
`else
    assign in_echo  = 1'b0;
`endif
    // The register address always takes priority so it never aliases memory.
    assign is_reg   = (a == BANK_REG_ADDR);
    assign in_mem   = !is_reg && (in_main || in_echo);
    assign hit      = ena && (is_reg || in_mem);

    // Echo wraps modulo the two-window span, reproducing the primary mapping.
    assign off_sel   = in_main ? off_main : off_echo;
    assign bank_sel  = off_sel[BANK_AW] ? bank_reg : '0;
    assign mem_index = {bank_sel, off_sel[BANK_AW-1:0]};

    assign rd_go  = ena && rd && !wr && hit;
    assign mem_we = ena && wr && in_mem;

    // A masked value of 0 would alias the fixed bank, so it selects bank 1.
    assign bank_next = (din[BW-1:0] == '0) ? BW'(1) : din[BW-1:0];

    // Register read value: unused upper bits read as 1.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reg_rd
            if (gi < BW) begin : g_bank_bit
                assign reg_rd_value[gi] = bank_reg[gi];
            end else begin : g_one_bit
                assign reg_rd_value[gi] = 1'b1;
            end
        end
    endgenerate

    // ---------------- control state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_reg     <= BW'(1);
            valid_reg    <= 1'b0;
            reg_sel_reg  <= 1'b0;
            reg_byte_reg <= 8'h00;
        end else begin
            if (ena && wr && is_reg) begin
                bank_reg <= bank_next;
            end
            valid_reg <= rd_go;
            if (rd_go) begin
                reg_sel_reg  <= is_reg;
                reg_byte_reg <= reg_rd_value;
            end
        end
    end

    // ---------------- storage ----------------
    // Single-port RAM with registered read; not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_index] <= din;
        end
        if (rd_go && in_mem) begin
            ram_q_reg <= mem[mem_index];
        end
    end

    assign bank = bank_reg;
    assign dout = valid_reg ? (reg_sel_reg ? reg_byte_reg : ram_q_reg) : 8'hzz;

endmodule
